// File: rtl/mem_req_arbiter.sv
// Arbitrates NUM_PORTS requesters onto a single-outstanding memory port and routes completions back.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module mem_req_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_PORTS-1:0]                  req_valid_i,
    input  logic [NUM_PORTS-1:0]                  req_wr_i,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata_i,
    output logic [NUM_PORTS-1:0]                  req_gnt_o,
    output logic [NUM_PORTS-1:0]                  resp_valid_o,
    output logic [DATA_WIDTH-1:0]                 resp_data_o,
    output logic                                  rd_req_valid_o,
    output logic                                  wr_req_valid_o,
    output logic [ADDR_WIDTH-1:0]                 req_address_o,
    output logic [DATA_WIDTH-1:0]                 wr_data_o,
    output logic [ID_WIDTH-1:0]                   req_id_o,
    input  logic                                  mem_data_valid_i,
    input  logic [DATA_WIDTH-1:0]                 mem_data_i,
    output logic                                  busy_o,
    output logic                                  err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state;
    logic                txn_wr;
    logic                any_req;
    logic [ID_WIDTH-1:0] win_id;

    assign any_req = |req_valid_i;

`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH:0]   rr_sum;
    logic [ID_WIDTH-1:0] rr_cand;
    logic                rr_found;

    // Search starts at the pointer and wraps past the last port back to 0.
    always_comb begin
        win_id   = '0;
        rr_found = 1'b0;
        rr_sum   = '0;
        rr_cand  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rr_sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(i);
            if (rr_sum >= (ID_WIDTH+1)'(NUM_PORTS))
                rr_sum = rr_sum - (ID_WIDTH+1)'(NUM_PORTS);
            rr_cand = rr_sum[ID_WIDTH-1:0];
            if (!rr_found && req_valid_i[rr_cand]) begin
                rr_found = 1'b1;
                win_id   = rr_cand;
            end
        end
    end
`else
    always_comb begin
        win_id = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (req_valid_i[i]) win_id = ID_WIDTH'(i);
    end
`endif

    // Grant is combinational from IDLE; masked while reset is held so all outputs read 0.
    assign req_gnt_o = (rst_i && state == IDLE && any_req) ? (NUM_PORTS'(1) << win_id) : '0;
    assign busy_o    = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= IDLE;
            txn_wr         <= 1'b0;
            resp_valid_o   <= '0;
            resp_data_o    <= '0;
            rd_req_valid_o <= 1'b0;
            wr_req_valid_o <= 1'b0;
            req_address_o  <= '0;
            wr_data_o      <= '0;
            req_id_o       <= '0;
            err_o          <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr         <= '0;
`endif
        end else begin
            rd_req_valid_o <= 1'b0;
            wr_req_valid_o <= 1'b0;
            resp_valid_o   <= '0;
            case (state)
                IDLE: begin
                    if (mem_data_valid_i) err_o <= 1'b1;
                    if (any_req) begin
                        // The memory request is launched from the grant edge so it is high during ISSUE.
                        req_address_o  <= req_addr_i[win_id];
                        wr_data_o      <= req_wdata_i[win_id];
                        txn_wr         <= req_wr_i[win_id];
                        req_id_o       <= win_id;
                        rd_req_valid_o <= ~req_wr_i[win_id];
                        wr_req_valid_o <= req_wr_i[win_id];
                        state          <= ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_ptr <= (win_id == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : win_id + 1'b1;
`endif
                    end
                end
                ISSUE: begin
                    if (mem_data_valid_i) err_o <= 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (mem_data_valid_i) begin
                        resp_valid_o <= NUM_PORTS'(1) << req_id_o;
                        if (!txn_wr) resp_data_o <= mem_data_i;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter (3 ports): directed stimulus pushes expectations, a negedge monitor checks.
module tb_mem_req_arbiter;
    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 2;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NP-1:0]          req_valid, req_wr;
    logic [NP-1:0][AW-1:0]  req_addr;
    logic [NP-1:0][DW-1:0]  req_wdata;
    logic [NP-1:0]          req_gnt, resp_valid;
    logic [DW-1:0]          resp_data, wr_data, mem_data;
    logic                   rd_req_valid, wr_req_valid, mem_data_valid, busy, err;
    logic [AW-1:0]          req_address;
    logic [IW-1:0]          req_id;

    mem_req_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .req_valid_i(req_valid), .req_wr_i(req_wr), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_gnt_o(req_gnt), .resp_valid_o(resp_valid), .resp_data_o(resp_data),
        .rd_req_valid_o(rd_req_valid), .wr_req_valid_o(wr_req_valid),
        .req_address_o(req_address), .wr_data_o(wr_data), .req_id_o(req_id),
        .mem_data_valid_i(mem_data_valid), .mem_data_i(mem_data),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; logic [IW-1:0] id; } mreq_t;
    typedef struct { int port; logic [DW-1:0] data; } resp_t;

    int    gq[$];
    mreq_t mq[$];
    resp_t rq[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {req_gnt, resp_valid, resp_data, rd_req_valid, wr_req_valid,
                 req_address, wr_data, req_id, busy, err}, '0);
    endtask

    task automatic expect_txn(input int p, input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic [DW-1:0] rdata, input bit with_resp);
        mreq_t m;
        resp_t r;
        m.wr = wr; m.addr = a; m.data = wd; m.id = IW'(p);
        r.port = p; r.data = rdata;
        gq.push_back(p);
        mq.push_back(m);
        if (with_resp) rq.push_back(r);
    endtask

    // Monitor: any DUT event pops its expectation; an event with nothing queued compares against 0.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_gnt != '0) begin
                if (gq.size() == 0) chk("gnt_spurious", 128'(req_gnt), 0);
                else chk("gnt", 128'(req_gnt), 128'(NP'(1) << gq.pop_front()));
            end
            if (rd_req_valid || wr_req_valid) begin
                if (mq.size() == 0) chk("memreq_spurious", {rd_req_valid, wr_req_valid}, 0);
                else begin
                    mreq_t m;
                    m = mq.pop_front();
                    chk("mem_dir", {wr_req_valid, rd_req_valid}, m.wr ? 2'b10 : 2'b01);
                    chk("mem_addr", 128'(req_address), 128'(m.addr));
                    chk("mem_id", 128'(req_id), 128'(m.id));
                    if (m.wr) chk("mem_wdata", 128'(wr_data), 128'(m.data));
                end
            end
            if (resp_valid != '0) begin
                if (rq.size() == 0) chk("resp_spurious", 128'(resp_valid), 0);
                else begin
                    resp_t r;
                    r = rq.pop_front();
                    chk("resp_valid", 128'(resp_valid), 128'(NP'(1) << r.port));
                    chk("resp_data", 128'(resp_data), 128'(r.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        mem_data_valid = 1'b0; mem_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;
        cyc(1);

        // Single read from port 1, memory answers two cycles after the issue cycle.
        req_valid = 3'b010; req_wr = '0; req_addr[1] = 32'h40;
        expect_txn(1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b1);
        cyc(1); req_valid = '0;
        @(negedge clk); chk("busy_issue", 128'(busy), 1);
        cyc(1);
        cyc(1); mem_data_valid = 1'b1; mem_data = 32'hDEADBEEF;
        cyc(1); mem_data_valid = 1'b0;
        cyc(1);

        // Port 0 write; response must leave resp_data untouched.
        req_valid = 3'b001; req_wr = 3'b001; req_addr[0] = 32'h80; req_wdata[0] = 32'h1234;
        expect_txn(0, 1'b1, 32'h80, 32'h1234, 32'hDEADBEEF, 1'b1);
        cyc(1); req_valid = '0; req_wr = '0;
        cyc(1); mem_data_valid = 1'b1; mem_data = 32'h5555;
        cyc(1); mem_data_valid = 1'b0;
        cyc(1);

        // Port 1 requests during port 0's WAIT; granted in port 0's response cycle.
        req_valid = 3'b001; req_addr[0] = 32'h200;
        expect_txn(0, 1'b0, 32'h200, 32'h0, 32'h11, 1'b1);
        expect_txn(1, 1'b0, 32'h300, 32'h0, 32'h22, 1'b1);
        cyc(1); req_valid = '0;
        cyc(1); req_valid = 3'b010; req_addr[1] = 32'h300;
        @(negedge clk); chk("no_gnt_wait0", 128'(req_gnt), 0);
        cyc(1); mem_data_valid = 1'b1; mem_data = 32'h11;
        @(negedge clk); chk("no_gnt_wait1", 128'(req_gnt), 0);
        cyc(1); mem_data_valid = 1'b0;
        @(negedge clk); chk("gnt_resp_same_cycle", {req_gnt, resp_valid}, {3'b010, 3'b001});
        cyc(1); req_valid = '0;
        cyc(1); mem_data_valid = 1'b1; mem_data = 32'h22;
        cyc(1); mem_data_valid = 1'b0;
        cyc(1);

        // Completion in IDLE is a protocol error, no response; reset clears it.
        mem_data_valid = 1'b1; mem_data = 32'h99;
        cyc(1); mem_data_valid = 1'b0;
        @(negedge clk); chk("err_idle", {err, resp_valid}, {1'b1, 3'b000});
        cyc(1); rst_n = 1'b0;
        #1; chk_all_zero("err_cleared_by_reset");
        cyc(1); rst_n = 1'b1;
        cyc(1);

        // All ports requesting continuously from a fresh reset (pointer 0).
        for (int p = 0; p < NP; p++) req_addr[p] = 32'h100 + 32'(p * 4);
        req_wr = '0; req_valid = 3'b111;
        for (int k = 0; k < (RR ? 4 : 3); k++) begin
            int p;
            p = RR ? (k % NP) : 0;
            expect_txn(p, 1'b0, 32'h100 + 32'(p * 4), 32'h0, 32'hA0 + 32'(k), 1'b1);
        end
        for (int k = 0; k < (RR ? 4 : 3); k++) begin
            cyc(1);
            cyc(1); mem_data_valid = 1'b1; mem_data = 32'hA0 + 32'(k);
            cyc(1); mem_data_valid = 1'b0;
            if (k == (RR ? 3 : 2)) req_valid = '0;
        end
        cyc(1);

        // Reset during WAIT abandons the transaction; a stale completion flags an error.
        req_valid = 3'b100; req_addr[2] = 32'h400;
        expect_txn(2, 1'b0, 32'h400, 32'h0, 32'h0, 1'b0);
        cyc(1); req_valid = '0;
        cyc(1); rst_n = 1'b0;
        #1; chk_all_zero("reset_in_wait");
        cyc(1); rst_n = 1'b1;
        cyc(1); mem_data_valid = 1'b1; mem_data = 32'h77;
        cyc(1); mem_data_valid = 1'b0;
        @(negedge clk); chk("stale_completion", {err, resp_valid, busy}, {1'b1, 3'b000, 1'b0});
        cyc(2);

        chk("gnt_drain", 128'(gq.size()), 0);
        chk("memreq_drain", 128'(mq.size()), 0);
        chk("resp_drain", 128'(rq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Parametrised arbiter that multiplexes NUM_PORTS requesters (fetch, load/store, future DMA/debug ports) onto the single-outstanding CPU memory port. It replaces the hard-wired "fetch wins" address mux at the CPU top. It also routes each completion back to the port that issued it. It sits between the pipeline stages and the external memory interface, with one transaction in flight at a time.

## Interface
- NUM_PORTS, 2, number of requesters; legal range 2..8
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, read/write data width
- ID_WIDTH, $clog2(NUM_PORTS), width of req_id_o; minimum 1

Ports:
- clk_i  input  1  clock; all logic is on the rising edge
- rst_i  input  1  asynchronous, active-low reset
- req_valid_i  input  NUM_PORTS  per-port request; held with a stable payload until granted
- req_wr_i  input  NUM_PORTS  per-port direction: 1 = write, 0 = read
- req_addr_i  input  [NUM_PORTS][ADDR_WIDTH]  per-port address
- req_wdata_i  input  [NUM_PORTS][DATA_WIDTH]  per-port write data
- req_gnt_o  output  NUM_PORTS  one-hot, one-cycle grant pulse; the request is captured in this cycle
- resp_valid_o  output  NUM_PORTS  one-hot, one-cycle completion pulse to the owning port
- resp_data_o  output  DATA_WIDTH  read data, valid with resp_valid_o
- rd_req_valid_o  output  1  one-cycle memory read request
- wr_req_valid_o  output  1  one-cycle memory write request
- req_address_o  output  ADDR_WIDTH  memory address
- wr_data_o  output  DATA_WIDTH  memory write data
- req_id_o  output  ID_WIDTH  index of the issuing port; generalises req_is_instr
- mem_data_valid_i  input  1  completion pulse from memory, for both reads and writes
- mem_data_i  input  DATA_WIDTH  read data, valid with mem_data_valid_i
- busy_o  output  1  high when the arbiter is not in IDLE
- err_o  output  1  sticky protocol-error flag

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - If any req_valid_i bit is set, select a winner (see Configuration).
  - Pulse req_gnt_o[winner] combinationally.
  - Latch the winner's address, write data, direction and index into the transaction register.
  - Next state is ISSUE.
- **ISSUE**
  - Drive rd_req_valid_o (read) or wr_req_valid_o (write) high for exactly one cycle.
  - req_address_o, wr_data_o and req_id_o come from the transaction register.
  - Next state is WAIT.
- **WAIT**
  - Hold req_address_o, wr_data_o and req_id_o stable.
  - On mem_data_valid_i, register resp_valid_o[owner]=1 for one cycle.
  - resp_data_o loads mem_data_i on a read; on a write it keeps its previous value.
  - Next state is IDLE.
- **Memory-side outputs**
  - req_address_o, wr_data_o and req_id_o are registered.
  - In IDLE they hold the values of the last transaction.
- **Protocol errors**
  - mem_data_valid_i in IDLE or ISSUE is ignored for routing and sets err_o.
  - err_o is cleared only by reset.
- **Requests during a transaction**
  - Requests arriving in ISSUE or WAIT are not granted.
  - Such requesters keep req_valid_i high.
  - Deasserting req_valid_i before the grant is legal: the request is withdrawn.

## Timing
- Reset values:
  - All outputs are 0, including req_gnt_o, resp_valid_o, resp_data_o, req_id_o and err_o.
  - State is IDLE; the round-robin pointer is 0.
- Latencies:
  - Grant in cycle G; memory request in G+1; earliest mem_data_valid_i in G+2; resp_valid_o in the cycle after mem_data_valid_i.
  - The cycle in which resp_valid_o is high is an IDLE cycle, so a new grant may coincide with it.
  - Minimum issue-to-issue period is 3 cycles plus memory latency.
- Simultaneous events:
  - resp_valid_o to port k and req_gnt_o to port k in the same cycle is legal.
  - A port may request again in the cycle it receives its response.
- Reset mid-transaction:
  - The transaction is abandoned immediately and no response is delivered.
  - A stale mem_data_valid_i arriving afterwards sets err_o.

## Configuration
- ARB_ROUND_ROBIN_EN
  - Defined: round-robin arbitration. After each grant, the pointer moves to (winner+1) mod NUM_PORTS. The search starts at the pointer and wraps past NUM_PORTS-1 to 0.
  - Undefined: fixed priority, lowest index wins. No pointer register exists. Port 0 is fetch, which preserves legacy behaviour.

## Test plan
- Reset, then single read from port 1, addr 0x40 with memory returning 0xDEADBEEF after 2 cycles -> req_gnt_o=2'b10, rd_req_valid_o pulse with req_id_o=1, resp_valid_o=2'b10, resp_data_o=0xDEADBEEF.
- Port 0 write, addr 0x80, data 0x1234 -> wr_req_valid_o pulse, wr_data_o=0x1234; on completion resp_valid_o=2'b01 and resp_data_o unchanged.
- NUM_PORTS=3, all ports requesting continuously:
  - With ARB_ROUND_ROBIN_EN -> grant order 0,1,2,0.
  - Without it -> 0,0,0.
- Port 1 requests while port 0's transaction is in WAIT -> no grant until port 0's response cycle; port 1 is granted in that same cycle.
- mem_data_valid_i pulsed in IDLE -> no resp_valid_o and err_o=1; then reset -> err_o=0.
- Reset asserted during WAIT -> outputs 0 immediately; a later mem_data_valid_i produces no response and sets err_o=1.
